xor_hash_engine_uram: RTL
=========================

# xor_hash_engine_uram

Iterative H3-style XOR hash engine that sits directly upstream of the per-bit XOR hash stages. It holds the Q matrix (one INDEX_WIDTH-bit row per key bit) and accepts a key over a valid/ready handshake. It walks the key BITS_PER_CYCLE bits per clock through a chain of and/xor stages, carrying the running XOR as the `pre` value between cycles. The finished INDEX_WIDTH-bit bucket index goes out over a second valid/ready handshake to the table-lookup logic.

## Interface
- INDEX_WIDTH, 12, width of hash index and of each Q row
- KEY_WIDTH, 32, key width; also the number of Q rows
- BITS_PER_CYCLE, 4, key bits folded per clock; must divide KEY_WIDTH
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- q_wr_en  input  1  write one Q row
- q_wr_addr  input  $clog2(KEY_WIDTH)  Q row index
- q_wr_data  input  INDEX_WIDTH  Q row value
- key_valid  input  1  key_data valid
- key_ready  output  1  engine can accept a key
- key_data  input  KEY_WIDTH  key to hash
- idx_valid  output  1  idx_data valid
- idx_ready  input  1  consumer accepts index
- idx_data  output  INDEX_WIDTH  hash result
- busy  output  1  high whenever state is not IDLE

## Operation
- Q matrix: KEY_WIDTH x INDEX_WIDTH registers, all cleared to 0 by reset.
- Q write rules:
  - q_wr_en is honoured only in IDLE; writes in HASH or DONE are dropped silently.
  - A write in cycle t is visible to a key accepted at t+1 or later.
  - A write and a key accept in the same cycle: the write lands, but that key hashes with the old row value.
- State machine: IDLE, HASH, DONE.
- IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: latch key_data, clear acc to 0, clear cnt to 0, go to HASH.
- HASH:
  - Each cycle, for j=0..BITS_PER_CYCLE-1 in order, with b=cnt*BITS_PER_CYCLE+j: acc = acc ^ (key[b] ? Q[b] : 0).
  - This is a combinational chain of BITS_PER_CYCLE and/xor stages, registered once per cycle.
  - cnt increments each cycle. When cnt == KEY_WIDTH/BITS_PER_CYCLE-1, register the final acc into idx_data and go to DONE.
- DONE:
  - idx_valid=1; idx_data holds stable.
  - On idx_ready: go to IDLE. idx_data keeps its last value; only idx_valid drops.
- Result is order-independent: idx = XOR over all b with key[b]=1 of Q[b]. key=0 gives 0.
- cnt width is $clog2(KEY_WIDTH/BITS_PER_CYCLE), minimum 1. It never wraps inside a key.
- Reset values: key_ready=0 while rst_n low, then 1 in IDLE; idx_valid=0; idx_data=0; busy=0; acc=0; cnt=0; state=IDLE.
- Reset asserted mid-HASH or in DONE aborts the key immediately; no index is emitted for it.

## Timing
- Key accepted at rising edge 0. HASH occupies edges 1..N, where N=KEY_WIDTH/BITS_PER_CYCLE.
- idx_valid goes high after edge N (N=8 with defaults).
- With idx_ready held high, DONE lasts one cycle. key_ready rises after edge N+1.
- Throughput: one key per N+2 cycles (accept cycle, N hash cycles, DONE cycle).
- key_ready is a function of state only, with no combinational path from key_valid.
- idx_valid is a function of state only; idx_ready never combinationally affects key_ready.
- idx_valid, once high, stays high with idx_data unchanged until the cycle idx_ready is sampled high.
- key_valid without key_ready (HASH/DONE) is ignored. The producer must hold the key.

## Test plan
- Load Q[i]=i+1 for i=0..31. Key 0x00000000 -> idx_valid after exactly 8 cycles, idx_data=0x000.
- Same Q, keys 0x00000001, 0x00000003, 0x80000001 back-to-back, idx_ready=1 -> idx_data 0x001, 0x003, 0x021; inter-accept spacing 10 cycles.
- Same Q, key 0xFFFFFFFF -> idx_data=0x020 (XOR of 1..32). Repeat with BITS_PER_CYCLE=1 and 8 -> same result, with latency 32 and 4.
- Backpressure: idx_ready low for 5 cycles after idx_valid -> idx_valid and idx_data (0x021) stable, key_ready=0, busy=1. Raise idx_ready -> next cycle IDLE, key_ready=1.
- Q write during HASH: write Q[0]=0xFFF mid-key for key 0x00000001 -> result 0x001. The next key 0x00000001 also returns 0x001 because the write was dropped.
- Pull rst_n low at HASH cycle 3 -> idx_valid never asserts, all Q rows read 0. After release, key 0x00000001 -> idx_data=0x000.

Source files
------------

// File: rtl/xor_hash_engine_uram_if.sv
`default_nettype none
// ============================================================================
//  Module   : xor_hash_engine_uram_if
//  Brief    : Q-row write port, key handshake and index handshake of the
//             iterative XOR hash engine.
//  Revision : 1.0
// ============================================================================
interface xor_hash_engine_uram_if #(
    parameter int INDEX_WIDTH = 12,
    parameter int KEY_WIDTH   = 32
);
    localparam int ADDR_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

    logic                   q_wr_en;
    logic [ADDR_W-1:0]      q_wr_addr;
    logic [INDEX_WIDTH-1:0] q_wr_data;
    logic                   key_valid;
    logic                   key_ready;
    logic [KEY_WIDTH-1:0]   key_data;
    logic                   idx_valid;
    logic                   idx_ready;
    logic [INDEX_WIDTH-1:0] idx_data;
    logic                   busy;

    // Producer / consumer side
    modport master (
        output q_wr_en, q_wr_addr, q_wr_data, key_valid, key_data, idx_ready,
        input  key_ready, idx_valid, idx_data, busy
    );

    // Hash engine side
    modport slave (
        input  q_wr_en, q_wr_addr, q_wr_data, key_valid, key_data, idx_ready,
        output key_ready, idx_valid, idx_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/xor_hash_engine_uram.sv
`default_nettype none
// ============================================================================
//  Module   : xor_hash_engine_uram
//  Brief    : Iterative H3-style XOR hash. Folds BITS_PER_CYCLE key bits per
//             clock against the Q matrix and emits an INDEX_WIDTH-bit index.
//  Revision : 1.0
// ============================================================================
module xor_hash_engine_uram #(
    parameter int INDEX_WIDTH    = 12,
    parameter int KEY_WIDTH      = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    xor_hash_engine_uram_if.slave   bus
);
    localparam int STEPS  = KEY_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int ADDR_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] q_mem [KEY_WIDTH];
    logic [KEY_WIDTH-1:0]   key_r;
    logic [INDEX_WIDTH-1:0] acc;
    logic [CNT_W-1:0]       cnt;
    logic [INDEX_WIDTH-1:0] idx_r;
    logic                   idx_valid_r;
    logic                   busy_r;

    // A Q write landing in the same cycle as a key accept must not be seen by
    // that key, so the overwritten row's old value is kept aside for it.
    logic                   shadow_vld;
    logic [ADDR_W-1:0]      shadow_addr;
    logic [INDEX_WIDTH-1:0] shadow_data;

    logic                   accept;
    logic                   q_write;
    logic [INDEX_WIDTH-1:0] acc_next;
    logic [ADDR_W-1:0]      bit_idx;
    logic [INDEX_WIDTH-1:0] row;

    assign accept  = (state == IDLE) && bus.key_valid;
    assign q_write = (state == IDLE) && bus.q_wr_en;

    // One and/xor stage per key bit handled this cycle, chained in bit order
    always_comb begin
        acc_next = acc;
        bit_idx  = '0;
        row      = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            bit_idx = ADDR_W'(int'(cnt) * BITS_PER_CYCLE + j);
            row     = (shadow_vld && (shadow_addr == bit_idx)) ? shadow_data
                                                               : q_mem[bit_idx];
            if (key_r[bit_idx]) begin
                acc_next = acc_next ^ row;
            end
        end
    end

    // Q matrix: writable only while idle, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (q_write) begin
            q_mem[bus.q_wr_addr] <= bus.q_wr_data;
        end
    end

    // Control FSM with registered index, valid and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_r       <= '0;
            acc         <= '0;
            cnt         <= '0;
            idx_r       <= '0;
            idx_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            shadow_vld  <= 1'b0;
            shadow_addr <= '0;
            shadow_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_r       <= bus.key_data;
                        acc         <= '0;
                        cnt         <= '0;
                        busy_r      <= 1'b1;
                        shadow_vld  <= q_write;
                        shadow_addr <= bus.q_wr_addr;
                        shadow_data <= q_mem[bus.q_wr_addr];
                        state       <= HASH;
                    end
                end
                HASH: begin
                    acc <= acc_next;
                    if (cnt == LAST_CNT) begin
                        idx_r       <= acc_next;
                        idx_valid_r <= 1'b1;
                        shadow_vld  <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.idx_ready) begin
                        idx_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    idx_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // key_ready decodes state only; it is held low while reset is applied
    assign bus.key_ready = rst_n && (state == IDLE);
    assign bus.idx_valid = idx_valid_r;
    assign bus.idx_data  = idx_r;
    assign bus.busy      = busy_r;

endmodule
`default_nettype wire
